// File: rtl/iob_rst_seq.sv
// Reset / clock-enable sequencer: qualifies PLL lock, stretches arst_o and raises cke_o ahead of release.
// Optional watchdog in RUN is compiled in when IOB_RST_SEQ_WDOG_EN is defined.
module iob_rst_seq #(
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int CKE_LEAD    = 2,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       ext_rst_i,
    input  logic       wdog_kick_i,
    output logic       arst_o,
    output logic       cke_o,
    output logic       ready_o,
    output logic [1:0] rst_cause_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOCK_WAIT = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_LEAD      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_EXT  = 2'd2;
    localparam logic [1:0] CAUSE_WDOG = 2'd3;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = (CKE_LEAD > 0) ? CNT_W'(CKE_LEAD - 1) : '0;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       cause_nxt;
    logic             wdog_trip;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

`ifdef IOB_RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_cnt;

    assign wdog_trip = (state == S_RUN) && !wdog_kick_i && (wdog_cnt == WDOG_LAST);

    // Only counts edges spent entirely inside RUN; the entry edge starts it at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wdog_cnt <= '0;
        end else if (state != S_RUN || state_nxt != S_RUN || wdog_kick_i) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= sat_inc(wdog_cnt);
        end
    end
`else
    logic wdog_unused;

    assign wdog_trip   = 1'b0;
    assign wdog_unused = wdog_kick_i | (WDOG_CYCLES == 0);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cause_nxt = rst_cause_o;
        case (state)
            S_IDLE: begin
                state_nxt = S_LOCK_WAIT;
                cnt_nxt   = '0;
            end
            S_LOCK_WAIT: begin
                if (!pll_locked_i) begin
                    cnt_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            S_HOLD: begin
                if (!pll_locked_i) begin
                    state_nxt = S_LOCK_WAIT;
                    cnt_nxt   = '0;
                end else if (ext_rst_i) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = (CKE_LEAD == 0) ? S_RUN : S_LEAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            S_LEAD: begin
                if (!pll_locked_i) begin
                    state_nxt = S_LOCK_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == LEAD_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            S_RUN: begin
                // Lock loss outranks the watchdog, which outranks the external request.
                if (!pll_locked_i) begin
                    state_nxt = S_LOCK_WAIT;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_LOCK;
                end else if (wdog_trip) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_WDOG;
                end else if (ext_rst_i) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_EXT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            arst_o      <= 1'b1;
            cke_o       <= 1'b0;
            ready_o     <= 1'b0;
            rst_cause_o <= CAUSE_POR;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            arst_o      <= (state_nxt != S_RUN);
            cke_o       <= (state_nxt == S_LEAD) || (state_nxt == S_RUN);
            ready_o     <= (state_nxt == S_RUN);
            rst_cause_o <= cause_nxt;
        end
    end

endmodule
